tlul_sram_slave: RTL
====================

// Module: tlul_sram_slave
// PURPOSE
// TL-UL slave endpoint in the clk_24 domain, directly downstream of tlul_interconnect_top's slave socket.
// Consumes the slave A channel and produces the slave D channel.
// Backs a small word-addressed register memory and services Get / PutFullData / PutPartialData.
// Holds one request outstanding at a time.
// Flags illegal accesses with d_error instead of hanging the bus.
// PARAMETERS
// ADDR_WIDTH    32           A-channel address width
// DATA_WIDTH    32           data width; MASK_WIDTH = DATA_WIDTH/8
// MASK_WIDTH    4            byte-mask width
// SIZE_WIDTH    3            a_size/d_size width
// SRC_WIDTH     2            source ID width
// SINK_WIDTH    1            sink ID width (d_sink driven 0)
// OPCODE_WIDTH  3            opcode width
// PARAM_WIDTH   3            param width
// BASE_ADDR     32'h0000_1000  byte address of word 0
// MEM_WORDS     16           number of DATA_WIDTH words; power of 2, >=2
// RESP_LATENCY  2            extra wait cycles between accept and d_valid (0..15)
// PORTS
// clk_24       in   1             slave-domain clock, all logic on posedge
// reset_n      in   1             asynchronous assert, active-low reset
// a_valid      in   1             A request valid
// a_ready      out  1             A request ready
// a_opcode     in   OPCODE_WIDTH  0=PutFull, 1=PutPartial, 4=Get
// a_param      in   PARAM_WIDTH   ignored
// a_size       in   SIZE_WIDTH    log2 bytes
// a_source     in   SRC_WIDTH     requester ID, echoed on d_source
// a_address    in   ADDR_WIDTH    byte address
// a_mask       in   MASK_WIDTH    byte enables
// a_data       in   DATA_WIDTH    write data
// d_valid      out  1             D response valid
// d_ready      in   1             D response ready
// d_opcode     out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
// d_param      out  PARAM_WIDTH   always 0
// d_size       out  SIZE_WIDTH    captured a_size
// d_source     out  SRC_WIDTH     captured a_source
// d_sink       out  SINK_WIDTH    always 0
// d_data       out  DATA_WIDTH    read data (0 for acks and errors)
// d_error      out  1             access was illegal
// BEHAVIOUR
// - Reset (reset_n=0, async):
//   - FSM=IDLE, d_valid=0, all d_* fields=0, latency counter=0.
//   - All memory words cleared to 0.
//   - a_ready=1 once reset_n deasserts.
//   - Reset mid-transaction drops the request with no response.
// - FSM IDLE -> WAIT -> RESP -> IDLE. a_ready = (state==IDLE), decoded directly from the state register.
// - IDLE:
//   - The accept edge is the clk_24 edge where a_valid&&a_ready.
//   - On that edge: latch opcode/size/source, evaluate legality, perform the memory write or read into d_data.
//   - Next state: WAIT if RESP_LATENCY>0 (counter loaded with RESP_LATENCY-1), else RESP.
// - WAIT: counter decrements each cycle; at 0 go to RESP. Total accept-to-d_valid = RESP_LATENCY+1 cycles.
// - RESP:
//   - d_valid=1; all d_* fields held stable until d_valid&&d_ready.
//   - On handshake: d_valid=0, next state IDLE, so a_ready rises the following cycle.
//   - d_ready low for any number of cycles stalls indefinitely without change.
// - There is no combinational path from any a_* or d_ready input to any output.
// - Index: idx = (a_address-BASE_ADDR)>>log2(MASK_WIDTH), truncated to log2(MEM_WORDS) bits.
// - Illegal access if any of the following hold:
//   - address < BASE_ADDR or address >= BASE_ADDR+MEM_WORDS*MASK_WIDTH;
//   - address not aligned to 2^a_size;
//   - a_size > log2(MASK_WIDTH);
//   - opcode not in {0,1,4}.
// - Illegal access: no memory write; d_error=1; d_data=0. d_opcode is 1 for Get, else 0; unknown opcodes answer 0.
// - PutFull (legal): writes bytes where a_mask=1; d_opcode=0; d_data=0.
// - PutPartial (legal): same, byte-masked.
// - Get (legal): d_data = mem[idx] (full word, mask ignored); d_opcode=1.
// - Top-address boundary: BASE_ADDR+4*(MEM_WORDS-1) is legal; +4*MEM_WORDS is illegal.
// TESTING
// - Reset then Get 0x1000 src=2 -> d_valid 3 cycles after accept; d_opcode=1, d_data=0, d_source=2, d_error=0.
// - PutFull 0x1004 data=A5A5A5A5 mask=F, then Get 0x1004 -> AccessAck (d_data=0), then d_data=A5A5A5A5.
// - PutPartial 0x1004 data=11223344 mask=0011, then Get -> d_data=A5A53344.
// - Get 0x1040 (one past end) and Put 0x0FFC -> d_error=1 and d_data=0; a following Get of 0x1000 still returns 0.
// - Hold d_ready=0 for 10 cycles in RESP -> d_* stable, a_ready=0 throughout; release -> IDLE and a_ready=1 next cycle.
// - Assert reset_n=0 during WAIT -> d_valid=0 immediately; after release a_ready=1 and Get 0x1004 returns 0.

Source files
------------

// File: rtl/tlul_sram_slave.sv
// TL-UL slave endpoint backing a small word-addressed register memory.
// One request outstanding; illegal accesses answer with d_error.
module tlul_sram_slave #(
    parameter int                  ADDR_WIDTH   = 32,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                  SIZE_WIDTH   = 3,
    parameter int                  SRC_WIDTH    = 2,
    parameter int                  SINK_WIDTH   = 1,
    parameter int                  OPCODE_WIDTH = 3,
    parameter int                  PARAM_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
    parameter int                  MEM_WORDS    = 16,
    parameter int                  RESP_LATENCY = 2
) (
    input  logic                    clk_24,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int OFF_W = $clog2(MASK_WIDTH);
    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] HI_ADDR =
        LO_ADDR + (ADDR_WIDTH+1)'(MEM_WORDS * MASK_WIDTH);

    localparam logic [3:0] CNT_LOAD =
        (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
    logic [SIZE_WIDTH-1:0]   d_size_q, d_size_d;
    logic [SRC_WIDTH-1:0]    d_source_q, d_source_d;
    logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;
    logic                    d_error_q, d_error_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0]   mem_d [MEM_WORDS];

    logic [ADDR_WIDTH:0]     addr_ext;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic                    aligned;
    logic                    size_ok;
    logic                    op_get;
    logic                    op_put;
    logic                    legal;
    logic                    accept;
    logic                    unused_ok;

    assign addr_ext   = {1'b0, a_address};
    assign in_range   = (addr_ext >= LO_ADDR) && (addr_ext < HI_ADDR);
    assign align_mask = ~({ADDR_WIDTH{1'b1}} << a_size);
    assign aligned    = (a_address & align_mask) == '0;
    assign size_ok    = a_size <= SIZE_WIDTH'(OFF_W);
    assign op_get     = a_opcode == OP_GET;
    assign op_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    assign legal      = in_range && aligned && size_ok && (op_get || op_put);
    assign offset     = a_address - BASE_ADDR;
    assign idx        = offset[OFF_W +: IDX_W];
    assign unused_ok  = ^{a_param, offset};

    // Handshake outputs decode the state register only.
    assign a_ready  = state_q == ST_IDLE;
    assign accept   = a_valid && a_ready;
    assign d_valid  = state_q == ST_RESP;
    assign d_opcode = d_opcode_q;
    assign d_param  = '0;
    assign d_size   = d_size_q;
    assign d_source = d_source_q;
    assign d_sink   = '0;
    assign d_data   = d_data_q;
    assign d_error  = d_error_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;
        mem_d      = mem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    d_opcode_d = op_get ? OP_ACK_DATA : OP_ACK;
                    d_size_d   = a_size;
                    d_source_d = a_source;
                    d_error_d  = !legal;
                    d_data_d   = (legal && op_get) ? mem_q[idx] : '0;
                    if (legal && op_put) begin
                        for (int b = 0; b < MASK_WIDTH; b++) begin
                            if (a_mask[b]) begin
                                mem_d[idx][8*b +: 8] = a_data[8*b +: 8];
                            end
                        end
                    end
                    if (RESP_LATENCY > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
